// File: rtl/cofre_pkg.sv
// Shared types and widths for the safe (cofre) input stage.
package cofre_pkg;

  localparam int LARGURA_SENHA = 4;
  localparam int LARGURA_ERROS = 3;

  typedef enum logic [1:0] {
    LIVRE,
    FECHADO,
    AVALIAR,
    BLOQUEADO
  } estado_t;

endpackage

// File: rtl/debounce_botao.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a single
// one-cycle pulse on each accepted rising edge.
module debounce_botao #(
  parameter int DEBOUNCE_CICLOS = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic botao,
  output logic pulso
);

  localparam int LARGURA_CONT = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [LARGURA_CONT-1:0] CONT_FIM = LARGURA_CONT'(DEBOUNCE_CICLOS - 1);
  localparam logic [LARGURA_CONT-1:0] CONT_UM  = LARGURA_CONT'(1);

  logic                    sinc_1;
  logic                    sinc_2;
  logic                    estavel;
  logic                    estavel_ant;
  logic [LARGURA_CONT-1:0] cont;

  always_ff @(posedge clk) begin
    if (rst) begin
      sinc_1      <= 1'b0;
      sinc_2      <= 1'b0;
      estavel     <= 1'b0;
      estavel_ant <= 1'b0;
      cont        <= '0;
      pulso       <= 1'b0;
    end else begin
      // NOTE: non-blocking so the two synchronizer stages shift one per clock
      // instead of collapsing into a single flop.
      sinc_1      <= botao;
      sinc_2      <= sinc_1;
      estavel_ant <= estavel;
      pulso       <= estavel & ~estavel_ant;
      // Any return to the accepted level restarts the stability window.
      if (sinc_2 == estavel) begin
        cont <= '0;
      end else if (cont == CONT_FIM) begin
        estavel <= sinc_2;
        cont    <= '0;
      end else begin
        cont <= cont + CONT_UM;
      end
    end
  end

endmodule

// File: rtl/entrada_cofre.sv
// Safe input stage: debounced buttons, senha/tentativa capture registers and
// the LIVRE/FECHADO/AVALIAR/BLOQUEADO state machine with lockout timer.
module entrada_cofre
  import cofre_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int MAX_ERROS       = 3,
  parameter int TEMPO_BLOQUEIO  = 250000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LARGURA_SENHA-1:0] chaves,
  input  logic                     btn_gravar,
  input  logic                     btn_testar,
  input  logic                     igual,
  output logic [LARGURA_SENHA-1:0] senha,
  output logic [LARGURA_SENHA-1:0] tentativa,
  output logic                     valido,
  output logic                     aberto,
  output logic                     bloqueado,
  output logic [LARGURA_ERROS-1:0] erros
);

  localparam int LARGURA_TIMER = (TEMPO_BLOQUEIO > 1) ? $clog2(TEMPO_BLOQUEIO) : 1;
  localparam logic [LARGURA_TIMER-1:0] TIMER_INICIO = LARGURA_TIMER'(TEMPO_BLOQUEIO - 1);
  localparam logic [LARGURA_TIMER-1:0] TIMER_UM     = LARGURA_TIMER'(1);
  localparam logic [LARGURA_ERROS-1:0] ERROS_MAX    = LARGURA_ERROS'(MAX_ERROS);
  localparam logic [LARGURA_ERROS:0]   ERROS_LIMITE = (LARGURA_ERROS + 1)'(MAX_ERROS);
  localparam logic [LARGURA_ERROS:0]   ERROS_UM     = (LARGURA_ERROS + 1)'(1);

  logic pulso_gravar;
  logic pulso_testar;

  estado_t                    estado,    estado_prox;
  logic [LARGURA_SENHA-1:0]   senha_prox;
  logic [LARGURA_SENHA-1:0]   tentativa_prox;
  logic [LARGURA_ERROS-1:0]   erros_prox;
  logic [LARGURA_TIMER-1:0]   timer,     timer_prox;
  logic [LARGURA_ERROS:0]     erros_inc;

  debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_gravar (
    .clk   (clk),
    .rst   (rst),
    .botao (btn_gravar),
    .pulso (pulso_gravar)
  );

  debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_testar (
    .clk   (clk),
    .rst   (rst),
    .botao (btn_testar),
    .pulso (pulso_testar)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= LIVRE;
      senha     <= '0;
      tentativa <= '0;
      erros     <= '0;
      timer     <= '0;
    end else begin
      estado    <= estado_prox;
      senha     <= senha_prox;
      tentativa <= tentativa_prox;
      erros     <= erros_prox;
      timer     <= timer_prox;
    end
  end

  // One extra bit so erros+1 cannot wrap before it is compared with the limit.
  assign erros_inc = {1'b0, erros} + ERROS_UM;

  always_comb begin
    // NOTE: every *_prox starts from its current value, so no branch leaves one
    // unassigned and no latch is inferred.
    estado_prox    = estado;
    senha_prox     = senha;
    tentativa_prox = tentativa;
    erros_prox     = erros;
    timer_prox     = timer;

    unique case (estado)
      LIVRE: begin
        if (pulso_gravar) begin
          senha_prox  = chaves;
          erros_prox  = '0;
          estado_prox = FECHADO;
        end
      end
      FECHADO: begin
        if (pulso_testar) begin
          tentativa_prox = chaves;
          estado_prox    = AVALIAR;
        end
      end
      AVALIAR: begin
        // The comparator has settled on the registered senha/tentativa by now.
        if (igual) begin
          erros_prox  = '0;
          estado_prox = LIVRE;
        end else if (erros_inc < ERROS_LIMITE) begin
          erros_prox  = erros_inc[LARGURA_ERROS-1:0];
          estado_prox = FECHADO;
        end else begin
          erros_prox  = ERROS_MAX;
          timer_prox  = TIMER_INICIO;
          estado_prox = BLOQUEADO;
        end
      end
      BLOQUEADO: begin
        if (timer == '0) begin
          erros_prox  = '0;
          estado_prox = FECHADO;
        end else begin
          timer_prox = timer - TIMER_UM;
        end
      end
      default: estado_prox = LIVRE;
    endcase
  end

  assign aberto    = (estado == LIVRE);
  assign bloqueado = (estado == BLOQUEADO);
  assign valido    = (estado == AVALIAR);

endmodule

// File: tb/tb_entrada_cofre.sv
// Self-checking bench for entrada_cofre: event-level model of the safe, a
// scoreboard queue of expected evaluations and a monitor keyed on valido.
module tb_entrada_cofre;

  localparam int DEB  = 4;
  localparam int MAXE = 3;
  localparam int TBLQ = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] chaves;
  logic       btn_gravar;
  logic       btn_testar;
  logic       igual;
  logic [3:0] senha;
  logic [3:0] tentativa;
  logic       valido;
  logic       aberto;
  logic       bloqueado;
  logic [2:0] erros;

  entrada_cofre #(
    .DEBOUNCE_CICLOS (DEB),
    .MAX_ERROS       (MAXE),
    .TEMPO_BLOQUEIO  (TBLQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .chaves     (chaves),
    .btn_gravar (btn_gravar),
    .btn_testar (btn_testar),
    .igual      (igual),
    .senha      (senha),
    .tentativa  (tentativa),
    .valido     (valido),
    .aberto     (aberto),
    .bloqueado  (bloqueado),
    .erros      (erros)
  );

  // Comparator downstream of this block.
  assign igual = (senha == tentativa);

  always #5 clk = ~clk;

  int n_check = 0;
  int n_fail  = 0;

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_check++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, got, exp, $time);
    end
  endtask

  // Event-level model of the safe.
  typedef struct {
    logic [3:0] tent;
    logic [3:0] senha;
    logic [2:0] erros;
    logic       aberto;
    logic       bloq;
  } esperado_t;

  esperado_t  fila[$];
  logic [3:0] m_senha;
  logic [3:0] m_tent;
  int         m_erros;
  logic       m_aberto;
  logic       m_bloq;

  task automatic modelo_reset();
    m_senha  = 4'd0;
    m_tent   = 4'd0;
    m_erros  = 0;
    m_aberto = 1'b1;
    m_bloq   = 1'b0;
  endtask

  task automatic modelo(input logic g, input logic t, input logic [3:0] v);
    if (m_bloq) return;
    if (m_aberto) begin
      if (g) begin
        m_senha  = v;
        m_erros  = 0;
        m_aberto = 1'b0;
      end
    end else if (t) begin
      m_tent = v;
      if (v == m_senha) begin
        m_erros  = 0;
        m_aberto = 1'b1;
      end else begin
        m_erros++;
        if (m_erros == MAXE) m_bloq = 1'b1;
      end
      fila.push_back('{tent: m_tent, senha: m_senha, erros: 3'(m_erros),
                       aberto: m_aberto, bloq: m_bloq});
    end
  endtask

  task automatic conferir(input string nome);
    check({nome, "_senha"},     senha,     m_senha);
    check({nome, "_tentativa"}, tentativa, m_tent);
    check({nome, "_erros"},     erros,     m_erros);
    check({nome, "_aberto"},    aberto,    m_aberto);
    check({nome, "_bloqueado"}, bloqueado, m_bloq);
  endtask

  // Press buttons at a negedge, hold, release and let everything settle.
  task automatic operar(input logic g, input logic t, input logic [3:0] v, input string nome);
    modelo(g, t, v);
    chaves     = v;
    btn_gravar = g;
    btn_testar = t;
    repeat (9) @(negedge clk);
    btn_gravar = 1'b0;
    btn_testar = 1'b0;
    repeat (12) @(negedge clk);
    if (m_bloq) begin
      repeat (TBLQ + 2) @(negedge clk);
      m_bloq  = 1'b0;
      m_erros = 0;
    end
    conferir(nome);
  endtask

  // Final wrong attempt that triggers lockout; returns at the first negedge
  // where bloqueado is visible.
  task automatic errar_ate_bloqueio();
    logic [3:0] v;
    v = ~m_senha;
    modelo(1'b0, 1'b1, v);
    chaves     = v;
    btn_testar = 1'b1;
    repeat (5) @(negedge clk);
    btn_testar = 1'b0;
    for (int i = 0; i < 20 && !bloqueado; i++) @(negedge clk);
    check("entra_bloqueio", bloqueado, 1);
  endtask

  // Monitor: every valido must match the next queued evaluation.
  initial begin
    esperado_t e;
    forever begin
      @(negedge clk);
      if (valido === 1'b1) begin
        check("fila_em_valido", fila.size() > 0, 1);
        if (fila.size() > 0) begin
          e = fila.pop_front();
          check("aval_tentativa", tentativa, e.tent);
          check("aval_senha",     senha,     e.senha);
          @(negedge clk);
          check("valido_um_ciclo", valido,    0);
          check("aval_erros",      erros,     e.erros);
          check("aval_aberto",     aberto,    e.aberto);
          check("aval_bloqueado",  bloqueado, e.bloq);
        end
      end
    end
  end

  initial begin
    #(100000 * 10);
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int lat;
    int pulsos;
    int n_bloq;
    int sel;
    logic [3:0] v;

    rst        = 1'b1;
    chaves     = 4'd0;
    btn_gravar = 1'b0;
    btn_testar = 1'b0;
    modelo_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_valido", valido, 0);
    conferir("rst");

    // Clean press: one pulse 7 cycles after the press, senha captured.
    modelo(1'b1, 1'b0, 4'd9);
    chaves     = 4'd9;
    btn_gravar = 1'b1;
    lat = 0;
    pulsos = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (dut.pulso_gravar) begin
        pulsos++;
        if (pulsos == 1) lat = i;
      end
      if (i == 10) btn_gravar = 1'b0;
    end
    check("gravar_latencia", lat, 2 + DEB + 1);
    check("gravar_pulsos", pulsos, 1);
    conferir("gravar9");

    // Bouncing press while closed: no pulse during bounce, one after settling.
    chaves = 4'd1;
    pulsos = 0;
    for (int k = 0; k < 20; k++) begin
      btn_gravar = ((k / 2) % 2) == 0;
      @(negedge clk);
      if (dut.pulso_gravar) pulsos++;
    end
    check("bounce_sem_pulso", pulsos, 0);
    btn_gravar = 1'b1;
    lat = 0;
    for (int i = 1; i <= 57; i++) begin
      @(negedge clk);
      if (dut.pulso_gravar) begin
        pulsos++;
        if (pulsos == 1) lat = i;
      end
    end
    check("bounce_latencia", lat, 2 + DEB + 1);
    check("bounce_pulso_unico", pulsos, 1);
    btn_gravar = 1'b0;
    repeat (12) @(negedge clk);
    conferir("gravar_fechado");

    // Correct attempt opens; new password then closes again.
    operar(1'b0, 1'b1, 4'd9, "acerto");
    operar(1'b1, 1'b0, 4'd3, "nova_senha");
    operar(1'b0, 1'b1, 4'd3, "abre3");
    operar(1'b1, 1'b0, 4'd9, "senha9");

    // Two wrong attempts, then a third that locks.
    operar(1'b0, 1'b1, 4'd5,  "erro1");
    operar(1'b0, 1'b1, 4'd12, "erro2");
    errar_ate_bloqueio();
    n_bloq = 1;
    for (int i = 1; i < 40; i++) begin
      if (i == 2) begin
        chaves     = 4'd9;
        btn_testar = 1'b1;
      end
      if (i == 8) btn_testar = 1'b0;
      @(negedge clk);
      if (bloqueado) n_bloq++;
      else break;
    end
    check("bloqueio_duracao", n_bloq, TBLQ);
    m_bloq  = 1'b0;
    m_erros = 0;
    repeat (15) @(negedge clk);
    conferir("pos_bloqueio");
    operar(1'b0, 1'b1, 4'd9, "abre_pos_bloqueio");

    // Gravar ignored while closed; simultaneous presses capture only the attempt.
    operar(1'b1, 1'b0, 4'd9, "fecha");
    operar(1'b1, 1'b0, 4'd1, "gravar_ignorado");
    operar(1'b1, 1'b1, 4'd4, "ambos");
    operar(1'b0, 1'b1, 4'd9, "abre_final");

    // Randomized operations against the model.
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 2);
      v   = ($urandom_range(0, 1) == 1) ? m_senha : 4'($urandom_range(0, 15));
      operar(sel != 1, sel != 0, v, "rand");
    end

    // Reset in the middle of a lockout and of a debounce.
    if (m_aberto) operar(1'b1, 1'b0, 4'($urandom_range(0, 15)), "prep_fecha");
    while (m_erros < MAXE - 1) operar(1'b0, 1'b1, ~m_senha, "prep_erro");
    errar_ate_bloqueio();
    @(negedge clk);
    btn_gravar = 1'b1;
    repeat (3) @(negedge clk);
    check("bloq_antes_rst", bloqueado, 1);
    rst        = 1'b1;
    btn_gravar = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    modelo_reset();
    m_bloq = 1'b0;
    check("rst2_valido", valido, 0);
    conferir("rst2");
    pulsos = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dut.pulso_gravar || dut.pulso_testar) pulsos++;
    end
    check("rst2_sem_pulso", pulsos, 0);
    operar(1'b1, 1'b0, 4'd6, "pos_rst_grava");
    operar(1'b0, 1'b1, 4'd6, "pos_rst_abre");

    repeat (5) @(negedge clk);
    check("fila_final", fila.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
